// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the word serializer slice.
//   state_t    : FSM state encoding (ST_IDLE = 0, ST_SHIFT = 1)
//   bit_cnt_w  : width of a bit counter that can hold 0 .. width-1
// -----------------------------------------------------------------------------
package serdes_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int bit_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
// Bundles the word handshake on the upstream side and the serial bit stream
// on the detector side of word_serializer.
//   in_valid, in_data, in_ready : valid/ready word transfer
//   w, w_valid                  : serial bit and its qualifier
//   frame_start                 : w carries the first bit of a word
//   busy                        : a word is shifting or held
// Modports: master = upstream/consumer side, slave = the serializer.
// -----------------------------------------------------------------------------
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             w;
    logic             w_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, w, w_valid, frame_start, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, w, w_valid, frame_start, busy
    );
endinterface

// File: rtl/word_hold_reg.sv
// -----------------------------------------------------------------------------
// word_hold_reg
// Single-entry word buffer used as the serializer's skid/hold slot.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, empties the buffer
//   wr_en    : write wr_data into the buffer
//   wr_data  : word to store
//   rd_en    : the stored word is consumed this cycle
//   rd_data  : stored word (valid while full)
//   full     : buffer holds a word
// A write together with a read while full replaces the contents and leaves
// full set. A write while full without a read is ignored, so the held word
// can never be silently overwritten.
// -----------------------------------------------------------------------------
module word_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] data;
    logic             wr_ok;

    assign wr_ok = wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (wr_ok) begin
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

    // NOTE: the data word is deliberately not reset; full qualifies it, and
    // leaving storage out of reset keeps it a plain enable register.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data <= wr_data;
        end
    end

    assign rd_data = data;

endmodule

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Parallel-to-serial stage feeding a bit-serial detector. Words arrive over a
// valid/ready handshake and leave one bit per clock on w. A one-word hold
// slot lets back-to-back words stream with no idle gap; with no data the
// output sits at IDLE_BIT.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : word_serializer_if.slave
//          in_valid/in_data/in_ready  upstream word handshake
//          w/w_valid                  serial bit and qualifier
//          frame_start                first bit of a word is on w
//          busy                       a word is shifting or held
// Parameters:
//   WIDTH     word width (>= 2)
//   MSB_FIRST 1 = bit WIDTH-1 goes out first, 0 = bit 0 first
//   IDLE_BIT  level driven on w when nothing is being shifted
// -----------------------------------------------------------------------------
module word_serializer
    import serdes_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    word_serializer_if.slave  bus
);

    localparam int             CW       = bit_cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sh, sh_next, sh_shifted;
    logic [CW-1:0]    cnt, cnt_next;
    logic             first, first_next;

    logic             in_ready;
    logic             accept;
    logic             hold_wr;
    logic             hold_rd;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;

    // Ready depends only on registered state and rst, never on in_valid.
    assign in_ready = !rst && !hold_full;
    assign accept   = bus.in_valid && in_ready;

    // Move the next bit into the output position.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_shifted = {sh[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign sh_shifted = {1'b0, sh[WIDTH-1:1]};
        end
    endgenerate

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hold_wr),
        .wr_data (bus.in_data),
        .rd_en   (hold_rd),
        .rd_data (hold_data),
        .full    (hold_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sh    <= '0;
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_next;
            sh    <= sh_next;
            cnt   <= cnt_next;
            first <= first_next;
        end
    end

    // NOTE: combinational block uses blocking assignments and gives every
    // output a default first, so no path through it can infer a latch.
    always_comb begin
        state_next = state;
        sh_next    = sh;
        cnt_next   = cnt;
        first_next = first;
        hold_wr    = 1'b0;
        hold_rd    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // Nothing in flight and the hold slot is empty here, so a new
                // word goes straight into the shifter.
                if (accept) begin
                    sh_next    = bus.in_data;
                    cnt_next   = CNT_LAST;
                    first_next = 1'b1;
                    state_next = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cnt != '0) begin
                    sh_next    = sh_shifted;
                    cnt_next   = cnt - 1'b1;
                    first_next = 1'b0;
                    hold_wr    = accept;
                end else if (hold_full) begin
                    // Last bit on w: the held word follows without a gap.
                    sh_next    = hold_data;
                    cnt_next   = CNT_LAST;
                    first_next = 1'b1;
                    hold_rd    = 1'b1;
                    hold_wr    = accept;
                end else if (accept) begin
                    // Hold is empty: a word arriving on the last bit bypasses it.
                    sh_next    = bus.in_data;
                    cnt_next   = CNT_LAST;
                    first_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    first_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Serial outputs are decoded from registers only.
    always_comb begin
        bus.w = IDLE_BIT;
        if (state == ST_SHIFT) begin
            bus.w = MSB_FIRST ? sh[WIDTH-1] : sh[0];
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.w_valid     = (state == ST_SHIFT);
    assign bus.frame_start = (state == ST_SHIFT) && first;
    assign bus.busy        = (state == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Drives two serializers with identical word streams: one MSB-first with
// IDLE_BIT=0, one LSB-first with IDLE_BIT=1. The reference model is a queue
// of bits still owed to the output: every accepted word appends its WIDTH
// bits in send order, every cycle with data emits the head bit. From the
// number of pending bits P the model derives every output:
//   w_valid = busy = P > 0, frame_start = P > 0 && P % WIDTH == 0,
//   in_ready = !rst && P <= WIDTH (at most one whole word may wait).
// -----------------------------------------------------------------------------
module tb_word_serializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(W)) bus_m ();
    word_serializer_if #(.WIDTH(W)) bus_l ();

    word_serializer #(
        .WIDTH     (W),
        .MSB_FIRST (1'b1),
        .IDLE_BIT  (1'b0)
    ) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    word_serializer #(
        .WIDTH     (W),
        .MSB_FIRST (1'b0),
        .IDLE_BIT  (1'b1)
    ) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic armed    = 1'b0;   // a reset edge has been applied
    logic q_m[$];            // bits owed by the MSB-first instance
    logic q_l[$];            // bits owed by the LSB-first instance

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
    // later, then advance the model at the rising edge.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                         output logic acc);
        logic rdy;
        int   p;
        rst            = r;
        bus_m.in_valid = v;
        bus_m.in_data  = d;
        bus_l.in_valid = v;
        bus_l.in_data  = d;
        #1;
        p   = q_m.size();
        rdy = !r && (p <= W);
        check("in_ready_m", bus_m.in_ready, rdy);
        check("in_ready_l", bus_l.in_ready, rdy);
        if (armed) begin
            check("w_valid_m", bus_m.w_valid, p > 0);
            check("w_valid_l", bus_l.w_valid, p > 0);
            check("busy_m", bus_m.busy, p > 0);
            check("busy_l", bus_l.busy, p > 0);
            check("frame_start_m", bus_m.frame_start, (p > 0) && (p % W == 0));
            check("frame_start_l", bus_l.frame_start, (p > 0) && (p % W == 0));
            check("w_m", bus_m.w, (p > 0) ? q_m[0] : 1'b0);
            check("w_l", bus_l.w, (p > 0) ? q_l[0] : 1'b1);
        end
        acc = v && rdy;
        @(posedge clk);
        if (r) begin
            q_m.delete();
            q_l.delete();
            armed = 1'b1;
        end else begin
            if (q_m.size() > 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
                for (int i = 0; i < W; i++)      q_l.push_back(d[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 1'b0, W'($urandom), acc);
    endtask

    // Hold in_valid with the word until it is taken, within a cycle budget.
    task automatic send(input logic [W-1:0] d);
        logic acc;
        int   n;
        n = 0;
        do begin
            cycle(1'b0, 1'b1, d, acc);
            n++;
        end while (!acc && n < 4 * W);
        check("send_accepted", acc, 1'b1);
    endtask

    initial begin
        logic acc;
        int   n;
        rst            = 1'b1;
        bus_m.in_valid = 1'b0;
        bus_m.in_data  = '0;
        bus_l.in_valid = 1'b0;
        bus_l.in_data  = '0;
        @(negedge clk);

        // Reset for three cycles, then idle.
        repeat (3) cycle(1'b1, 1'b0, '0, acc);
        idle(5);

        // Single word, then drain back to idle.
        send(8'hF0);
        idle(10);

        // Back-to-back words with valid held high.
        send(8'h0F);
        send(8'h00);
        send(8'hFF);
        idle(2 * W + 4);

        // Hold bypass: next word first offered on the last bit of 8'h3C.
        send(8'h3C);
        n = 0;
        while (q_m.size() != 1 && n < 2 * W) begin
            idle(1);
            n++;
        end
        check("bypass_reached_last_bit", q_m.size() == 1, 1'b1);
        send(8'hA5);
        idle(W + 3);

        // LSB-first pattern on both instances.
        send(8'h01);
        idle(W + 2);

        // Reset on bit 3 of 8'hC3 while another word sits in hold.
        send(8'hC3);
        send(8'h5A);
        idle(1);
        cycle(1'b1, 1'b0, '0, acc);
        idle(W + 4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r, v;
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 99) < 70);
            cycle(r, v, W'($urandom), acc);
        end
        idle(2 * W + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial stage that feeds the bit-serial run-length detector (4-in-a-row 0/1 Mealy FSM) on its single-bit input `w`.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock.
- A one-word hold buffer allows back-to-back words to stream with no idle gap.
- Drives IDLE_BIT when it has no data, so the detector sees a defined level.

Parameters:
- WIDTH, 8, word width in bits (must be at least 2).
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first.
- IDLE_BIT, 1'b0, value driven on `w` when no word is being shifted.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream word available.
- in_data  input  WIDTH  upstream word, sampled when in_valid && in_ready.
- in_ready  output  1  serializer can accept a word this cycle.
- w  output  1  serial bit to the detector.
- w_valid  output  1  w carries a data bit, not idle fill.
- frame_start  output  1  high while w carries the first bit of a word.
- busy  output  1  a word is shifting or held.

Behaviour:
- States: IDLE, SHIFT.
- Registers: shift reg `sh[WIDTH]`, bit counter `cnt` (clog2(WIDTH) bits), `hold[WIDTH]`, `hold_full`, `first` flag.
- Reset (rst high at a clock edge):
  - state=IDLE, hold_full=0, cnt=0, sh=0, first=0.
  - Outputs after reset: w=IDLE_BIT, w_valid=0, frame_start=0, busy=0.
  - in_ready is forced 0 while rst is high.
- Reset mid-operation discards the in-flight word and the held word. No partial bits are emitted after the edge.
- Accept rule: transfer occurs when in_valid && in_ready.
- in_ready = !rst && !hold_full. It is combinational from registers and rst only. There is no path from in_valid to in_ready.
- Output decode: w, w_valid and frame_start are decoded from registers only. No combinational path from in_* to w.
  - SHIFT: w = sh[WIDTH-1] if MSB_FIRST, else sh[0].
  - IDLE: w = IDLE_BIT.
  - w_valid = (state==SHIFT). frame_start = (state==SHIFT) && first.
- IDLE + accept:
  - Word loads directly into sh; cnt=WIDTH-1; first=1; go to SHIFT.
  - Latency: word accepted at edge t puts its first bit on w in cycle t+1.
- SHIFT, cnt!=0: shift sh by one toward the output end; cnt-1; first=0.
  - Any accept goes into hold; hold_full=1.
- SHIFT, cnt==0 (last bit on w), next word priority:
  - If hold_full: load sh<-hold, cnt=WIDTH-1, first=1, stay SHIFT. hold_full clears unless a new word is accepted the same edge, in which case hold<-in_data and hold_full stays 1.
  - Else if accepting this cycle (hold is empty, so in_ready=1): bypass hold, sh<-in_data, cnt=WIDTH-1, first=1, stay SHIFT.
  - Else go to IDLE.
- Result: a continuous input stream yields w_valid high every cycle, with no bubble between words.
- busy = (state==SHIFT) || hold_full.
- Ordering: words are emitted strictly in acceptance order. No word is dropped or duplicated.
- in_data is don't-care when no transfer occurs. sh and hold change only on the edges described above.

Decomposition:
- Shared package `serdes_pkg` holds:
  - state encoding localparams (ST_IDLE=0, ST_SHIFT=1);
  - function `bit_cnt_w(WIDTH)` returning clog2(WIDTH).
- One natural sub-module: `word_hold_reg`, a single-entry buffer.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full.
  - Simultaneous rd_en and wr_en while full → replace contents, full stays 1.
- The top level keeps the FSM, counter and shift register.

Test Plan:
- Reset then idle: hold rst 3 cycles, release, keep in_valid=0 for 5 cycles → w=IDLE_BIT, w_valid=0, busy=0, in_ready=1 every cycle after release. in_ready=0 while rst is high.
- Single word, MSB_FIRST=1: 8'hF0 accepted at cycle 0 → cycles 1..8 carry w=1,1,1,1,0,0,0,0 with w_valid=1, frame_start only in cycle 1. Cycle 9 returns to IDLE. The downstream detector's z rises on bit 4 (fourth 1) and bit 8 (fourth 0).
- Back-to-back: 8'h0F, 8'h00, 8'hFF offered with in_valid held high → 24 contiguous w_valid cycles, frame_start in cycles 1, 9 and 17. in_ready drops while hold is full and re-rises on the edge hold is loaded into sh.
- Hold bypass: second word 8'hA5 first asserted exactly in the last-bit cycle of 8'h3C → 8'hA5's first bit appears the next cycle with no gap, and hold_full never sets.
- LSB-first: MSB_FIRST=0, word 8'h01 → w=1,0,0,0,0,0,0,0.
- Reset mid-operation: rst asserted on bit 3 of 8'hC3 with a word held → next cycle w=IDLE_BIT, w_valid=0, busy=0. The held word is never emitted.
